// File: rtl/mem_access_unit.sv
// Load/store front-end for a masked BRAM: error 1 cycle, store 2, load 3 (accept to rsp_valid).
// One request in flight; req_ready is high only in IDLE, and input changes while busy are ignored.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wr_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_out,
  input  logic [31:0]       mem_data_in
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we, r_uns;
  logic [1:0]  r_size, r_off;
  logic        w_accept, w_err, w_misalign, w_oor;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata, w_ld;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid & req_ready;
  // Any address bit above the BRAM's byte range makes the access out of range.
  assign w_oor     = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign w_err     = w_misalign | w_oor;

  always_comb begin
    w_misalign = 1'b0;
    w_mask     = 4'b1111;
    w_wdata    = req_wdata;
    case (req_size)
      2'b00: begin
        w_mask  = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = req_addr[0];
        w_mask     = 4'b0011 << req_addr[1:0];
        w_wdata    = {2{req_wdata[15:0]}};
      end
      2'b10:   w_misalign = |req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = mem_data_in[7:0];
    case (r_off)
      2'd1:    w_byte = mem_data_in[15:8];
      2'd2:    w_byte = mem_data_in[23:16];
      2'd3:    w_byte = mem_data_in[31:24];
      default: w_byte = mem_data_in[7:0];
    endcase
    w_half = r_off[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (r_size)
      2'b00:   w_ld = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_ld = mem_data_in;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_state_nxt = r_we ? S_RESP : S_WAIT;
      S_WAIT:   w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_size       <= 2'b00;
      r_off        <= 2'b00;
      mem_en       <= 1'b0;
      mem_wr_mask  <= 4'b0000;
      mem_addr     <= '0;
      mem_data_out <= 32'd0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= 32'd0;
    end else begin
      // Strobes default low so mem_en/mask/rsp_valid are single-cycle pulses.
      mem_en      <= 1'b0;
      mem_wr_mask <= 4'b0000;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we   <= req_we;
            r_uns  <= req_unsigned;
            r_size <= req_size;
            r_off  <= req_addr[1:0];
            if (w_err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'd0;
            end else begin
              mem_en       <= 1'b1;
              mem_addr     <= req_addr[ADDR_W+1:2];
              mem_wr_mask  <= req_we ? w_mask : 4'b0000;
              mem_data_out <= w_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
          end
        end
        S_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= w_ld;
        end
        default: ;
      endcase
    end
  end

endmodule
